led_pulse_stretcher: RTL and testbench
======================================

# led_pulse_stretcher

Output-side counterpart to the board's input conditioning path: converts single-cycle internal event strobes into human-visible LED blinks. Each accepted event produces one blink of fixed on-time followed by a mandatory off-gap, so back-to-back events stay distinguishable. Events arriving while a blink is in progress are queued in a saturating counter and replayed. Sits between core status strobes (e.g. halt, trap, UART byte) and the FPGA LED pins.

## Interface
Parameters:
- `ON_CYCLES`, default 10_000_000 — LED high time per blink (100 ms at 100 MHz); must be ≥ 1.
- `OFF_CYCLES`, default 5_000_000 — minimum LED low gap after each blink; must be ≥ 1.
- `MAX_PENDING`, default 7 — maximum queued events; must be ≥ 1.

Ports:
- `clk` input 1 — system clock; all logic on rising edge.
- `rst` input 1 — synchronous, active-low reset.
- `trigger` input 1 — event strobe; every cycle it is sampled high counts as one event.
- `overflow_clr` input 1 — clears `overflow`.
- `out` output 1 — LED drive, registered.
- `busy` output 1 — high whenever state ≠ IDLE.
- `pending` output $clog2(MAX_PENDING+1) — queued event count.
- `overflow` output 1 — sticky; an event was dropped.

## Operation
- State machine: IDLE, ON, GAP. A single timer counter, width $clog2(max(ON_CYCLES, OFF_CYCLES)+1), is reloaded to 0 on every state entry.
- IDLE: `out`=0. `trigger`=1 → ON; `pending` unchanged.
- ON: `out`=1. Stays for exactly ON_CYCLES cycles, then → GAP. `trigger`=1 → `pending`+1.
- GAP: `out`=0. Stays for exactly OFF_CYCLES cycles. `trigger`=1 → `pending`+1.
- Last GAP cycle: the effective count is `pending` + `trigger`.
  - If it is > 0 → ON, and `pending` ← effective − 1. There is no overflow in this cycle, because a slot is freed.
  - Otherwise → IDLE.
- Saturation: when `trigger`=1 in ON/GAP, outside the last GAP cycle, with `pending`==MAX_PENDING, `pending` holds and `overflow` is set.
- `overflow` clears only on `overflow_clr`=1 or reset. If a set and `overflow_clr` occur in the same cycle, set wins.
- `out` = (state==ON), registered together with the state; no combinational path from `trigger`.
- Reset (`rst`=0): state ← IDLE, timer ← 0.
  - Outputs reset to `out`=0, `busy`=0, `pending`=0, `overflow`=0.
  - Reset aborts a blink or gap in progress at the next edge.
  - `trigger` is ignored while `rst`=0.

## Timing
- Trigger sampled at edge t in IDLE: `out`=1 for cycles t+1 … t+ON_CYCLES; GAP for the next OFF_CYCLES cycles; IDLE at t+ON_CYCLES+OFF_CYCLES+1 if nothing is pending.
- Queued blinks: the next ON starts the cycle after the last GAP cycle. The blink period is ON_CYCLES+OFF_CYCLES with no idle cycle between blinks.
- `busy`, `pending` and `overflow` update on the same edge as the state change or event that causes them.
- `trigger` held high for N cycles = N events.

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2, MAX_PENDING=2.
- Reset: hold `rst`=0 for 3 cycles with `trigger`=1 → `out`=0, `busy`=0, `pending`=0, `overflow`=0 throughout; no blink after release.
- Single event: `trigger` at cycle 0 → `out`=1 in cycles 1–4, 0 in cycles 5–6; `busy`=1 in cycles 1–6; IDLE and `busy`=0 at cycle 7.
- Burst and saturation: `trigger` at cycles 0, 1, 2, 3 → `pending`=1, then 2 (cycles 2–3); `overflow`=1 from cycle 4. Blinks at cycles 1–4, 7–10 and 13–16. `pending`=1 at cycle 7 and 0 at cycle 13. IDLE at cycle 19.
- Last-gap coincidence: single event at cycle 0, second `trigger` at cycle 6 (last GAP cycle) → `out`=1 in cycles 7–10; `pending` stays 0; `overflow` stays 0.
- Reset mid-blink: `trigger` at cycle 0, `rst`=0 at cycle 2 → `out`=0 and `busy`=0 from cycle 3; queued events cleared; a new `trigger` after release blinks normally.
- Overflow clear priority: with `pending`=2 in ON, assert `trigger` and `overflow_clr` together → `overflow`=1. `overflow_clr` alone on a later cycle → `overflow`=0 on the next edge.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
// Turns single-cycle event strobes into visible LED blinks. Each event gives
// one ON_CYCLES-long blink followed by an OFF_CYCLES-long low gap. Events that
// arrive during a blink or gap are queued in a saturating counter and replayed
// back to back.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous reset, active low
//   trigger      - event strobe, one event per cycle sampled high
//   overflow_clr - clears the sticky overflow flag
//   out          - LED drive (registered)
//   busy         - high while not idle (registered)
//   pending      - queued event count (registered)
//   overflow     - sticky flag, an event was dropped (registered)
module led_pulse_stretcher #(
    parameter int unsigned ON_CYCLES   = 10_000_000,
    parameter int unsigned OFF_CYCLES  = 5_000_000,
    parameter int unsigned MAX_PENDING = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 trigger,
    input  logic                                 overflow_clr,
    output logic                                 out,
    output logic                                 busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending,
    output logic                                 overflow
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);
    localparam int unsigned PW      = $clog2(MAX_PENDING + 1);
    localparam int unsigned EW      = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [PW-1:0]   r_pending;
    logic            r_overflow;
    logic            r_out;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [PW-1:0]   w_pending_nxt;
    logic            w_overflow_nxt;
    logic            w_ovf_set;
    logic            w_last_on;
    logic            w_last_gap;
    logic [EW-1:0]   w_eff;

    // State, timer and all outputs register together
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
            r_out      <= (w_state_nxt == ST_ON);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state, queue and overflow logic
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_ovf_set     = 1'b0;
        w_last_on     = (r_timer == TW'(ON_CYCLES - 1));
        w_last_gap    = (r_timer == TW'(OFF_CYCLES - 1));
        // Queue depth as seen in the final gap cycle, including this cycle's event
        w_eff         = {1'b0, r_pending} + EW'(trigger);

        case (r_state)
            ST_IDLE: begin
                if (trigger) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (trigger) begin
                    if (r_pending == PW'(MAX_PENDING)) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_pending_nxt = r_pending + PW'(1);
                    end
                end
                if (w_last_on) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_last_gap) begin
                    // One slot is consumed by the next blink, so nothing drops here
                    if (w_eff != '0) begin
                        w_state_nxt   = ST_ON;
                        w_pending_nxt = PW'(w_eff - EW'(1));
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end else if (trigger) begin
                    if (r_pending == PW'(MAX_PENDING)) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_pending_nxt = r_pending + PW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new drop beats a same-cycle clear
        if (w_ovf_set) begin
            w_overflow_nxt = 1'b1;
        end else if (overflow_clr) begin
            w_overflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt = r_overflow;
        end

        // Timer restarts on every state entry and idles at zero
        if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    assign out      = r_out;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed testbench for led_pulse_stretcher with ON=4, OFF=2, MAX_PENDING=2.
// "Cycle c" is the interval after rising edge c; inputs set in cycle c are
// sampled at edge c+1, and outputs are observed 1 time unit after edge c.
module tb_led_pulse_stretcher;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 2;
    localparam int unsigned MAXP  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       overflow_clr;
    logic       out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    led_pulse_stretcher #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .overflow_clr(overflow_clr),
        .out         (out),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_out, input logic e_busy,
                           input logic [1:0] e_pend, input logic e_ovf);
        chk({tag, ".out"},      32'(out),      32'(e_out));
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".pending"},  32'(pending),  32'(e_pend));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    // Bit c of each vector gives trigger / expected value for cycle c
    task automatic run_seq(input string tag, input int n, input logic [31:0] trig,
                           input logic [31:0] e_out, input logic [31:0] e_busy,
                           input logic [31:0] e_p0, input logic [31:0] e_p1,
                           input logic [31:0] e_ovf);
        trigger = trig[0];
        tick();
        for (int c = 1; c <= n; c++) begin
            chk_all($sformatf("%s.c%0d", tag, c), e_out[c], e_busy[c],
                    {e_p1[c], e_p0[c]}, e_ovf[c]);
            trigger = trig[c];
            if (c < n) tick();
        end
        trigger = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        trigger      = 1'b1;
        overflow_clr = 1'b0;

        // Reset held with trigger high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset.c%0d", i), 1'b0, 1'b0, 2'd0, 1'b0);
        end
        rst     = 1'b1;
        trigger = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("post_reset.c%0d", i), 1'b0, 1'b0, 2'd0, 1'b0);
        end

        // Single event: out cycles 1-4, busy 1-6, idle at 7
        run_seq("single", 7, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0);

        // Burst of 4: third queued event saturates
        run_seq("burst", 19, 32'hF, 32'h1E79E, 32'h7FFFE, 32'h1F84, 32'h78, 32'hFFFF0);

        // Clear sticky overflow
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk_all("ovf_clr", 1'b0, 1'b0, 2'd0, 1'b0);

        // Trigger in last gap cycle chains straight into a new blink
        run_seq("lastgap", 13, 32'h41, 32'h79E, 32'h1FFE, 32'h0, 32'h0, 32'h0);

        // Reset mid-blink clears queue and aborts blink
        trigger = 1'b1;
        tick();
        chk_all("midrst.c1", 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        chk_all("midrst.c2", 1'b1, 1'b1, 2'd1, 1'b0);
        trigger = 1'b0;
        rst     = 1'b0;
        tick();
        chk_all("midrst.c3", 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("midrst.c4", 1'b0, 1'b0, 2'd0, 1'b0);
        run_seq("after_rst", 7, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0);

        // Overflow set beats same-cycle clear
        trigger = 1'b1;
        tick();
        tick();
        tick();
        chk_all("prio.c3", 1'b1, 1'b1, 2'd2, 1'b0);
        overflow_clr = 1'b1;
        tick();
        chk_all("prio.c4", 1'b1, 1'b1, 2'd2, 1'b1);
        trigger = 1'b0;
        tick();
        chk_all("prio.c5", 1'b0, 1'b1, 2'd2, 1'b0);
        overflow_clr = 1'b0;

        // Drain to idle within a bounded window
        for (int i = 0; i < 40 && busy; i++) tick();
        chk_all("drain", 1'b0, 1'b0, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
